uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx serializer among N_REQ byte-stream requesters (debug, status, cmd-reply).
//  Grants per message: the winner keeps the UART until its byte with req_last is sent.
//  Round-robin at message granularity; a stalled message is dropped by a lock timeout.
//  Sits between client logic and uart_tx (tx_data/tx_data_valid/tx_data_ready).
// PARAMETERS
//  N_REQ        4        number of requesters, 2..8
//  LOCK_TIMEOUT 65535    cycles in S_LOAD without granted req_valid before the grant is dropped
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous reset, active low
//  req_data     in   8*N_REQ    byte from requester i at [8*i+7:8*i]
//  req_valid    in   N_REQ      requester i presents a byte
//  req_last     in   N_REQ      presented byte is the last of its message
//  req_ready    out  N_REQ      byte from requester i consumed this cycle
//  uart_data    out  8          to uart_tx tx_data
//  uart_valid   out  1          to uart_tx tx_data_valid
//  uart_ready   in   1          from uart_tx tx_data_ready
//  grant        out  N_REQ      one-hot current owner, 0 when idle
//  busy         out  1          grant != 0
//  timeout_err  out  1          1-cycle pulse: owner's message aborted by timeout
//  timeout_id   out  3          index of aborted owner, held until next abort
// BEHAVIOUR
//  Design: one clock, reset asynchronous and active-low. Reset: state=S_IDLE, grant=0,
//  uart_valid=0, uart_data=0, rr_ptr=0, timeout_err=0, timeout_id=0, counter=0.
//  Reset mid-message drops the message; uart_valid falls immediately.
//  UART handshake: byte transfers on uart_valid && uart_ready. uart_tx holds ready 0 after reset
//  and during a frame, so uart_valid may sit high for many cycles; uart_data is stable while high.
//  States:
//   S_IDLE: if |req_valid, pick the first set bit at or after rr_ptr (cyclic), register grant,
//           go S_LOAD. rr_ptr = winner+1 mod N_REQ. No valid: stay.
//   S_LOAD: req_ready[g] = req_valid[g] (comb, only here, only owner). On valid: capture byte and
//           last into out regs, uart_valid<=1, clear counter, go S_SEND.
//           Else counter++; at LOCK_TIMEOUT-1: grant<=0, pulse timeout_err, timeout_id<=g, S_IDLE.
//   S_SEND: hold uart_valid/uart_data. On uart_ready: uart_valid<=0; last ? (grant<=0, S_IDLE)
//           : S_LOAD.
//  Latency: req_valid in S_IDLE -> grant next cycle -> req_ready same cycle as grant if valid
//  held -> uart_valid the cycle after. Arbitration overhead <=2 cycles, negligible vs one frame.
//  Boundaries: requesters idle -> grant 0, nothing driven. Only one requester -> consecutive
//  messages by it allowed, separated by one S_IDLE cycle. rr_ptr wraps N_REQ-1 -> 0.
//  New requests during a message wait, never preempt. Non-owner req_ready is always 0.
//  req_last on a 1-byte message ends the grant after that byte. Counter is 16 bits; it never
//  runs in S_SEND (UART backpressure is not a timeout). Simultaneous valid from all: lowest
//  index >= rr_ptr wins. Unused timeout_id bits are zero.
// STRUCTURE
//  Package uart_arb_pkg: state enum {S_IDLE,S_LOAD,S_SEND}, IDX_W = $clog2(N_REQ) helper.
//  Sub-module rr_pick: combinational rotating-priority picker (req vector + ptr -> one-hot + idx).
//  Top holds FSM, out byte/last regs, rr_ptr, timeout counter. Target ~200 lines.
// TESTING
//  (bench: uart_tx instance, CLK_FRE=1, BAUD=100000 -> 10 cycles/bit; serial decoder on tx_pin)
//  T1 reset: rst_n low mid-S_SEND -> uart_valid=0, grant=0 same cycle; after release, idle.
//  T2 req0 sends 0x41,0x42,last 0x43 -> tx_pin decodes A,B,C in order; grant=0001 throughout.
//  T3 req0..3 all valid, 1-byte msgs 0x10..0x13 -> serial order 10,11,12,13, then 10 again.
//  T4 req2 mid-message with req1 valid -> req1 waits; req2 bytes contiguous, then grant=0010.
//  T5 LOCK_TIMEOUT=20, req3 sends 0x55 without last, drops valid -> timeout_err pulse at
//     cycle 20 in S_LOAD, timeout_id=3, grant 0; pending req0 granted next.
//  T6 uart_ready held low 500 cycles in S_SEND -> no timeout; uart_data stable; req_ready=0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } state_t;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned CNT_W  = 16;

    // Index width for an N-entry requester vector (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, cyclically.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0] pick_idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // Scan N_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found             = 1'b1;
                pick_onehot[cand] = 1'b1;
                pick_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx among N_REQ byte streams.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8*N_REQ-1:0]    req_data,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic [BYTE_W-1:0]     uart_data,
    output logic                  uart_valid,
    input  logic                  uart_ready,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [ID_W-1:0]       timeout_id
);

    localparam int unsigned      IDX_W        = idx_width(N_REQ);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic               last_q;
    logic [CNT_W-1:0]   counter;

    logic [N_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    logic [BYTE_W-1:0]  owner_data;
    logic               owner_valid;
    logic               owner_last;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .found       (pick_found)
    );

    // Select the current owner's byte, valid and last flag.
    always_comb begin
        owner_data  = '0;
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                owner_data  = req_data[8*i +: 8];
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
            end
        end
    end

    // Only the owner may see ready, and only while a byte is being loaded.
    assign req_ready = (state == S_LOAD) ? (grant & req_valid) : '0;
    assign busy      = |grant;

    // Arbitration FSM with registered UART-side outputs and lock timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant       <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            last_q      <= 1'b0;
            counter     <= '0;
            uart_data   <= '0;
            uart_valid  <= 1'b0;
            timeout_err <= 1'b0;
            timeout_id  <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant   <= pick_onehot;
                        owner   <= pick_idx;
                        rr_ptr  <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                        counter <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (owner_valid) begin
                        uart_data  <= owner_data;
                        last_q     <= owner_last;
                        uart_valid <= 1'b1;
                        counter    <= '0;
                        state      <= S_SEND;
                    end else if (counter == TIMEOUT_LAST) begin
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        timeout_id  <= ID_W'(owner);
                        counter     <= '0;
                        state       <= S_IDLE;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                S_SEND: begin
                    if (uart_ready) begin
                        uart_valid <= 1'b0;
                        if (last_q) begin
                            grant <= '0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                default: begin
                    grant      <= '0;
                    uart_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: byte-queue requesters, a uart_tx-like ready model, and a transfer log.
module tb_uart_tx_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned LT    = 20;
    localparam int          FRAME = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     uart_data;
    logic           uart_valid;
    logic           uart_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_err;
    logic [2:0]     timeout_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .uart_data   (uart_data),
        .uart_valid  (uart_valid),
        .uart_ready  (uart_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] src_byte [N][16];
    logic       src_last [N][16];
    int         src_wr [N];
    int         src_rd [N];
    logic [N-1:0] en;

    logic [7:0] log_data  [64];
    int         log_owner [64];
    int         log_cyc   [64];
    int         log_n;

    logic       hold;
    int         ucnt;
    logic [N-1:0] fire;
    logic       uacc;
    logic [7:0] cap_data;
    int         cap_owner;

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = 7;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        src_byte[r][src_wr[r]] = b;
        src_last[r][src_wr[r]] = l;
        src_wr[r]++;
    endtask

    // Requester queues and the uart_tx ready model; handshakes captured 1 ns before each posedge.
    initial begin
        fire = '0; uacc = 1'b0; ucnt = 3; cap_data = '0; cap_owner = 0;
        req_valid = '0; req_data = '0; req_last = '0; uart_ready = 1'b0;
        for (int i = 0; i < N; i++) begin src_wr[i] = 0; src_rd[i] = 0; end
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin src_wr[i] = 0; src_rd[i] = 0; end
                en = '0; fire = '0; uacc = 1'b0; ucnt = 3;
            end else begin
                for (int i = 0; i < N; i++) if (fire[i]) src_rd[i]++;
                if (uacc) begin
                    log_data[log_n]  = cap_data;
                    log_owner[log_n] = cap_owner;
                    log_cyc[log_n]   = cyc;
                    log_n++;
                    ucnt = FRAME;
                end else if (ucnt > 0) begin
                    ucnt--;
                end
            end
            uart_ready = (ucnt == 0) && !hold && rst_n;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = en[i] && (src_rd[i] < src_wr[i]);
                req_data[8*i +: 8] = req_valid[i] ? src_byte[i][src_rd[i]] : 8'h00;
                req_last[i]        = req_valid[i] ? src_last[i][src_rd[i]] : 1'b0;
            end
            #4;
            fire      = req_ready & req_valid;
            uacc      = uart_valid && uart_ready;
            cap_data  = uart_data;
            cap_owner = onehot_idx(grant);
        end
    end

    logic [7:0] exp3 [5];
    int         own3 [5];
    int         to_cyc;
    logic       seen;
    int         bad;

    initial begin
        rst_n = 1'b0; hold = 1'b0; en = '0; log_n = 0;
        exp3[0] = 8'h10; exp3[1] = 8'h11; exp3[2] = 8'h12; exp3[3] = 8'h13; exp3[4] = 8'h10;
        own3[0] = 0; own3[1] = 1; own3[2] = 2; own3[3] = 3; own3[4] = 0;
        repeat (3) tick();

        // Reset values
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_uart_valid", 32'(uart_valid), 32'h0);
        check("rst_uart_data", 32'(uart_data), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        check("rst_timeout_id", 32'(timeout_id), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_grant", 32'(grant), 32'h0);

        // T2: three-byte message from req0
        log_n = 0;
        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
        en[0] = 1'b1;
        for (int k = 0; k < 300 && log_n < 3; k++) tick();
        check("t2_count", 32'(log_n), 32'd3);
        check("t2_b0", 32'(log_data[0]), 32'h41);
        check("t2_b1", 32'(log_data[1]), 32'h42);
        check("t2_b2", 32'(log_data[2]), 32'h43);
        for (int i = 0; i < 3; i++) check("t2_owner", 32'(log_owner[i]), 32'd0);
        for (int k = 0; k < 20 && busy; k++) tick();
        check("t2_release", 32'(grant), 32'h0);

        // T1: reset while a byte waits in S_SEND
        log_n = 0; hold = 1'b1;
        push(2, 8'h99, 1'b1);
        en[2] = 1'b1;
        for (int k = 0; k < 50 && !uart_valid; k++) tick();
        check("t1_valid_before", 32'(uart_valid), 32'h1);
        check("t1_data_before", 32'(uart_data), 32'h99);
        rst_n = 1'b0;
        #1;
        check("t1_valid_async", 32'(uart_valid), 32'h0);
        check("t1_grant_async", 32'(grant), 32'h0);
        check("t1_busy_async", 32'(busy), 32'h0);
        tick(); tick();
        rst_n = 1'b1; hold = 1'b0;
        repeat (10) tick();
        check("t1_idle_grant", 32'(grant), 32'h0);
        check("t1_idle_valid", 32'(uart_valid), 32'h0);
        check("t1_nothing_sent", 32'(log_n), 32'd0);

        // T3: all four requesters, rr_ptr starting at 0
        log_n = 0;
        push(0, 8'h10, 1'b1); push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1);
        push(3, 8'h13, 1'b1); push(0, 8'h10, 1'b1);
        en = 4'b1111;
        for (int k = 0; k < 500 && log_n < 5; k++) tick();
        check("t3_count", 32'(log_n), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("t3_data", 32'(log_data[i]), 32'(exp3[i]));
            check("t3_owner", 32'(log_owner[i]), 32'(own3[i]));
        end
        for (int k = 0; k < 20 && busy; k++) tick();

        // T4: req1 arrives while req2 owns the UART
        log_n = 0; en = 4'b0100;
        push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        for (int k = 0; k < 50 && grant != 4'b0100; k++) tick();
        check("t4_grant2", 32'(grant), 32'h4);
        push(1, 8'h30, 1'b1);
        en[1] = 1'b1;
        tick(); tick();
        check("t4_req1_valid", 32'(req_valid[1]), 32'h1);
        check("t4_req1_not_ready", 32'(req_ready[1]), 32'h0);
        check("t4_still_grant2", 32'(grant), 32'h4);
        for (int k = 0; k < 500 && log_n < 4; k++) tick();
        check("t4_count", 32'(log_n), 32'd4);
        check("t4_b0", 32'(log_data[0]), 32'h20);
        check("t4_b1", 32'(log_data[1]), 32'h21);
        check("t4_b2", 32'(log_data[2]), 32'h22);
        check("t4_b3", 32'(log_data[3]), 32'h30);
        check("t4_o0", 32'(log_owner[0]), 32'd2);
        check("t4_o2", 32'(log_owner[2]), 32'd2);
        check("t4_o3", 32'(log_owner[3]), 32'd1);
        for (int k = 0; k < 20 && busy; k++) tick();

        // T5: req3 stalls mid-message, lock timeout hands over to req0
        log_n = 0; en = 4'b1000;
        push(3, 8'h55, 1'b0);
        for (int k = 0; k < 50 && log_n < 1; k++) tick();
        check("t5_b0", 32'(log_data[0]), 32'h55);
        push(0, 8'h66, 1'b1);
        en[0] = 1'b1;
        seen = 1'b0; to_cyc = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            if (timeout_err) begin seen = 1'b1; to_cyc = cyc; end
        end
        check("t5_seen", 32'(seen), 32'h1);
        check("t5_delay", 32'(to_cyc - log_cyc[0]), 32'd20);
        check("t5_id", 32'(timeout_id), 32'd3);
        check("t5_grant_drop", 32'(grant), 32'h0);
        tick();
        check("t5_pulse", 32'(timeout_err), 32'h0);
        check("t5_grant0", 32'(grant), 32'h1);
        check("t5_id_held", 32'(timeout_id), 32'd3);
        for (int k = 0; k < 100 && log_n < 2; k++) tick();
        check("t5_b1", 32'(log_data[1]), 32'h66);
        check("t5_o1", 32'(log_owner[1]), 32'd0);
        for (int k = 0; k < 20 && busy; k++) tick();

        // T6: long UART backpressure is not a timeout
        log_n = 0; en = 4'b0010; hold = 1'b1;
        push(1, 8'h77, 1'b1); push(1, 8'h78, 1'b1);
        for (int k = 0; k < 50 && !uart_valid; k++) tick();
        check("t6_data", 32'(uart_data), 32'h77);
        bad = 0;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (!uart_valid || uart_data != 8'h77 || timeout_err || req_ready != '0 || grant != 4'b0010)
                bad++;
        end
        check("t6_stable_cycles_bad", 32'(bad), 32'd0);
        check("t6_req1_waiting", 32'(req_valid[1]), 32'h1);
        hold = 1'b0;
        for (int k = 0; k < 200 && log_n < 2; k++) tick();
        check("t6_b0", 32'(log_data[0]), 32'h77);
        check("t6_b1", 32'(log_data[1]), 32'h78);
        for (int k = 0; k < 20 && busy; k++) tick();
        check("t6_idle", 32'(grant), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
